// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 16-bit ALU for the general-purpose 16-bit processor datapath.
//
// Eighteen operations are selected by a 5-bit opcode. Single-cycle operations
// register their result and Z/N/C/V flags on the edge where op/A/B are
// sampled. Signed DIV (2), MOD (5) and MUL (7) run on one shared sequential
// engine that is launched by a `start` pulse and reports completion on its
// own done line.
//
// Build option:
//   ALU_MULDIV_EN  defined     -> sign-magnitude shift-add / restoring engine,
//                                 result 17 edges after the start edge.
//                  not defined -> no engine; DIV/MOD/MUL with start return
//                                 result 0, V=1 and pulse the done line at once.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   launches DIV/MOD/MUL when op is 2/5/7
//   op[4:0]      in   opcode
//   A[15:0]      in   operand A (dividend, multiplicand, shift source)
//   B[15:0]      in   operand B (B[3:0] is the shift/rotate amount)
//   result[15:0] out  registered result (MUL low half)
//   result_high  out  MUL high half, 0 after any other op
//   done_div/mod/mul  out  one-cycle completion pulses
//   Z, N, C, V   out  registered flags
// ---------------------------------------------------------------------------
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  op,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] result,
    output logic [15:0] result_high,
    output logic        done_div,
    output logic        done_mod,
    output logic        done_mul,
    output logic        Z,
    output logic        N,
    output logic        C,
    output logic        V
);

    localparam logic [4:0] OP_AND = 5'd0;
    localparam logic [4:0] OP_DEC = 5'd1;
    localparam logic [4:0] OP_DIV = 5'd2;
    localparam logic [4:0] OP_INC = 5'd3;
    localparam logic [4:0] OP_LSH = 5'd4;
    localparam logic [4:0] OP_MOD = 5'd5;
    localparam logic [4:0] OP_MOV = 5'd6;
    localparam logic [4:0] OP_MUL = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8;
    localparam logic [4:0] OP_OR  = 5'd9;
    localparam logic [4:0] OP_ADD = 5'd10;
    localparam logic [4:0] OP_RSH = 5'd11;
    localparam logic [4:0] OP_ROL = 5'd12;
    localparam logic [4:0] OP_ROR = 5'd13;
    localparam logic [4:0] OP_SUB = 5'd14;
    localparam logic [4:0] OP_TST = 5'd15;
    localparam logic [4:0] OP_XOR = 5'd16;
    localparam logic [4:0] OP_CMP = 5'd17;

    logic        eng_op_s;
    logic [3:0]  amt_s;
    logic [16:0] add_s, inc_s, sub_s, dec_s, lsh_s, rsh_s;
    logic [15:0] rol_s, ror_s;
    logic [15:0] sc_result_s, sc_flag_src_s;
    logic        sc_c_s, sc_v_s, sc_valid_s, sc_z_s, sc_n_s;
    logic [15:0] fin_result_s, fin_high_s;
    logic        fin_z_s, fin_n_s, fin_v_s;
    logic [4:0]  fin_op_s;
    logic        eng_busy_s, eng_fin_s;

    assign eng_op_s = (op == OP_DIV) || (op == OP_MOD) || (op == OP_MUL);
    assign amt_s    = B[3:0];

    // Single-cycle datapath: result, carry/overflow and the value Z/N look at.
    always_comb begin
        add_s = {1'b0, A} + {1'b0, B};
        inc_s = {1'b0, A} + 17'd1;
        sub_s = {1'b0, A} - {1'b0, B};
        dec_s = {1'b0, A} - 17'd1;
        // Bit 16 of the left shift / bit 0 of the right shift is the last bit out.
        lsh_s = {1'b0, A} << amt_s;
        rsh_s = {A, 1'b0} >> amt_s;
        rol_s = (A << amt_s) | (A >> (5'd16 - {1'b0, amt_s}));
        ror_s = (A >> amt_s) | (A << (5'd16 - {1'b0, amt_s}));
        sc_result_s = 16'd0;
        sc_c_s      = 1'b0;
        sc_v_s      = 1'b0;
        sc_valid_s  = 1'b1;
        case (op)
            OP_AND: sc_result_s = A & B;
            OP_DEC: begin
                sc_result_s = dec_s[15:0];
                sc_c_s      = dec_s[16];
                sc_v_s      = ~A[15] & dec_s[15] ? 1'b0 : (A[15] & ~dec_s[15]);
            end
            OP_INC: begin
                sc_result_s = inc_s[15:0];
                sc_c_s      = inc_s[16];
                sc_v_s      = ~A[15] & inc_s[15];
            end
            OP_LSH: begin
                sc_result_s = lsh_s[15:0];
                sc_c_s      = lsh_s[16];
            end
            OP_MOV: sc_result_s = A;
            OP_NOT: sc_result_s = ~A;
            OP_OR:  sc_result_s = A | B;
            OP_ADD: begin
                sc_result_s = add_s[15:0];
                sc_c_s      = add_s[16];
                sc_v_s      = (A[15] == B[15]) && (add_s[15] != A[15]);
            end
            OP_RSH: begin
                sc_result_s = rsh_s[16:1];
                sc_c_s      = rsh_s[0];
            end
            OP_ROL: sc_result_s = rol_s;
            OP_ROR: sc_result_s = ror_s;
            OP_SUB: begin
                sc_result_s = sub_s[15:0];
                sc_c_s      = sub_s[16];
                sc_v_s      = (A[15] != B[15]) && (sub_s[15] != A[15]);
            end
            OP_TST: sc_result_s = A & B;
            OP_XOR: sc_result_s = A ^ B;
            OP_CMP: begin
                sc_result_s = A;
                sc_c_s      = sub_s[16];
                sc_v_s      = (A[15] != B[15]) && (sub_s[15] != A[15]);
            end
            // Engine opcodes and unused opcodes 18-31: zero result, all flags clear.
            default: sc_valid_s = 1'b0;
        endcase
        // CMP reports the flags of A-B while passing A through.
        sc_flag_src_s = (op == OP_CMP) ? sub_s[15:0] : sc_result_s;
        sc_z_s        = sc_valid_s && (sc_flag_src_s == 16'd0);
        sc_n_s        = sc_valid_s && sc_flag_src_s[15];
    end

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} eng_state_t;

    eng_state_t  state_r, state_next_s;
    logic        launch_s;
    logic [4:0]  op_r;
    logic [15:0] a_r, mag_a_r, mag_b_r, mag_a_in_s, mag_b_in_s;
    logic        sign_a_r, sign_b_r, div_zero_r, div_ovf_r;
    logic [3:0]  count_r;
    // MUL: {high, low} product; DIV/MOD: {remainder, dividend/quotient}.
    logic [31:0] work_r, work_next_s, prod_s;
    logic [16:0] mul_sum_s, div_shift_s;
    logic        div_ge_s;
    logic [15:0] div_rem_s, quo_s, rem_s;

    assign launch_s   = (state_r == ST_IDLE) && start && eng_op_s;
    assign mag_a_in_s = A[15] ? (16'd0 - A) : A;
    assign mag_b_in_s = B[15] ? (16'd0 - B) : B;

    // Engine state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Engine next-state: 16 RUN cycles, one DONE cycle.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: state_next_s = launch_s ? ST_RUN : ST_IDLE;
            ST_RUN:  state_next_s = (count_r == 4'd15) ? ST_DONE : ST_RUN;
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // One shift-add or restoring-divide step on the unsigned magnitudes.
    always_comb begin
        mul_sum_s   = {1'b0, work_r[31:16]} + (work_r[0] ? {1'b0, mag_a_r} : 17'd0);
        div_shift_s = {work_r[31:16], work_r[15]};
        div_ge_s    = div_shift_s >= {1'b0, mag_b_r};
        // The remainder stays below the divisor, so 16-bit wrap is exact.
        div_rem_s   = div_ge_s ? (div_shift_s[15:0] - mag_b_r) : div_shift_s[15:0];
        if (op_r == OP_MUL) begin
            work_next_s = {mul_sum_s, work_r[15:1]};
        end else begin
            work_next_s = {div_rem_s, work_r[14:0], div_ge_s};
        end
    end

    // Engine operand latch and iteration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r       <= 5'd0;
            a_r        <= 16'd0;
            mag_a_r    <= 16'd0;
            mag_b_r    <= 16'd0;
            sign_a_r   <= 1'b0;
            sign_b_r   <= 1'b0;
            div_zero_r <= 1'b0;
            div_ovf_r  <= 1'b0;
            count_r    <= 4'd0;
            work_r     <= 32'd0;
        end else if (launch_s) begin
            op_r       <= op;
            a_r        <= A;
            mag_a_r    <= mag_a_in_s;
            mag_b_r    <= mag_b_in_s;
            sign_a_r   <= A[15];
            sign_b_r   <= B[15];
            div_zero_r <= (B == 16'd0);
            div_ovf_r  <= (A == 16'h8000) && (B == 16'hFFFF);
            count_r    <= 4'd0;
            work_r     <= (op == OP_MUL) ? {16'd0, mag_b_in_s} : {16'd0, mag_a_in_s};
        end else if (state_r == ST_RUN) begin
            count_r <= count_r + 4'd1;
            work_r  <= work_next_s;
        end
    end

    // Sign restoration and flags of the finished engine operation.
    always_comb begin
        quo_s        = work_r[15:0];
        rem_s        = work_r[31:16];
        prod_s       = (sign_a_r ^ sign_b_r) ? (32'd0 - work_r) : work_r;
        fin_result_s = 16'd0;
        fin_high_s   = 16'd0;
        fin_v_s      = 1'b0;
        case (op_r)
            OP_MUL: begin
                fin_result_s = prod_s[15:0];
                fin_high_s   = prod_s[31:16];
                fin_v_s      = prod_s[31:16] != {16{prod_s[15]}};
            end
            OP_DIV: begin
                if (div_zero_r) begin
                    fin_result_s = 16'hFFFF;
                    fin_v_s      = 1'b1;
                end else begin
                    // -32768/-1 yields magnitude 16'h8000 with positive sign.
                    fin_result_s = (sign_a_r ^ sign_b_r) ? (16'd0 - quo_s) : quo_s;
                    fin_v_s      = div_ovf_r;
                end
            end
            OP_MOD: begin
                if (div_zero_r) begin
                    fin_result_s = a_r;
                    fin_v_s      = 1'b1;
                end else begin
                    fin_result_s = sign_a_r ? (16'd0 - rem_s) : rem_s;
                    fin_v_s      = 1'b0;
                end
            end
            default: fin_result_s = 16'd0;
        endcase
        fin_z_s = (op_r == OP_MUL) ? (prod_s == 32'd0) : (fin_result_s == 16'd0);
        fin_n_s = (op_r == OP_MUL) ? prod_s[31] : fin_result_s[15];
    end

    assign fin_op_s   = op_r;
    assign eng_busy_s = (state_r != ST_IDLE);
    assign eng_fin_s  = (state_r == ST_DONE);
`else
    // Without the engine, DIV/MOD/MUL complete immediately with V=1.
    assign fin_result_s = 16'd0;
    assign fin_high_s   = 16'd0;
    assign fin_z_s      = 1'b0;
    assign fin_n_s      = 1'b0;
    assign fin_v_s      = 1'b1;
    assign fin_op_s     = op;
    assign eng_busy_s   = 1'b0;
    assign eng_fin_s    = start && eng_op_s;
`endif

    // Output register: engine completion, single-cycle update, or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= 16'd0;
            result_high <= 16'd0;
            Z           <= 1'b0;
            N           <= 1'b0;
            C           <= 1'b0;
            V           <= 1'b0;
            done_div    <= 1'b0;
            done_mod    <= 1'b0;
            done_mul    <= 1'b0;
        end else if (eng_fin_s) begin
            result      <= fin_result_s;
            result_high <= fin_high_s;
            Z           <= fin_z_s;
            N           <= fin_n_s;
            C           <= 1'b0;
            V           <= fin_v_s;
            done_div    <= (fin_op_s == OP_DIV);
            done_mod    <= (fin_op_s == OP_MOD);
            done_mul    <= (fin_op_s == OP_MUL);
        end else if (!eng_busy_s && !eng_op_s) begin
            result      <= sc_result_s;
            result_high <= 16'd0;
            Z           <= sc_z_s;
            N           <= sc_n_s;
            C           <= sc_c_s;
            V           <= sc_v_s;
            done_div    <= 1'b0;
            done_mod    <= 1'b0;
            done_mul    <= 1'b0;
        end else begin
            done_div    <= 1'b0;
            done_mod    <= 1'b0;
            done_mul    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu. Directed steps from the test plan
// plus randomized operations, compared against an arithmetic reference model.
// Follows the ALU_MULDIV_EN build option of the design.
// ---------------------------------------------------------------------------
module tb_alu;

`ifdef ALU_MULDIV_EN
    localparam bit ENGINE = 1'b1;
`else
    localparam bit ENGINE = 1'b0;
`endif

    logic        clk, rst, start;
    logic [4:0]  op;
    logic [15:0] A, B, result, result_high;
    logic        done_div, done_mod, done_mul, Z, N, C, V;

    int n_assert = 0;
    int n_fail   = 0;

    alu dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .result(result), .result_high(result_high),
        .done_div(done_div), .done_mod(done_mod), .done_mul(done_mul),
        .Z(Z), .N(N), .C(C), .V(V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference for single-cycle ops: {result[15:0], Z, N, C, V}.
    function automatic logic [19:0] model_sc(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, r, fr, s, n;
        logic c, v, valid;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b); n = b[3:0];
        c = 1'b0; v = 1'b0; valid = 1'b1; s = 0;
        case (o)
            5'd0:  r = ua & ub;
            5'd1:  begin r = ua - 1; c = (ua < 1); s = sa - 1; v = (s < -32768); end
            5'd3:  begin r = ua + 1; c = (r > 65535); s = sa + 1; v = (s > 32767); end
            5'd4:  begin r = ua << n; c = (n > 0) && (((ua >> (16 - n)) & 1) != 0); end
            5'd6:  r = ua;
            5'd8:  r = ~ua;
            5'd9:  r = ua | ub;
            5'd10: begin r = ua + ub; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
            5'd11: begin r = ua >> n; c = (n > 0) && (((ua >> (n - 1)) & 1) != 0); end
            5'd12: r = (ua << n) | (ua >> (16 - n));
            5'd13: r = (ua >> n) | (ua << (16 - n));
            5'd14: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
            5'd15: r = ua & ub;
            5'd16: r = ua ^ ub;
            5'd17: begin r = ua; c = (ua < ub); s = sa - sb; v = (s > 32767) || (s < -32768); end
            default: begin r = 0; valid = 1'b0; end
        endcase
        fr = (o == 5'd17) ? (ua - ub) : r;
        return {r[15:0], valid && (fr[15:0] == 16'd0), valid && fr[15], c, v};
    endfunction

    // Reference for DIV/MOD/MUL: {result_high, result, Z, N, C, V}.
    function automatic logic [35:0] model_eng(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
        int sa, sb, q;
        longint p;
        logic [15:0] res, hi;
        logic z, n, v;
        sa = $signed(a); sb = $signed(b);
        hi = 16'd0; v = 1'b0;
        if (o == 5'd7) begin
            p = longint'(sa) * longint'(sb);
            res = p[15:0]; hi = p[31:16];
            z = (p == 0); n = (p < 0); v = (p > 32767) || (p < -32768);
        end else begin
            if (sb == 0) begin
                res = (o == 5'd2) ? 16'hFFFF : a; v = 1'b1;
            end else if (o == 5'd2) begin
                q = sa / sb; res = q[15:0]; v = (q > 32767);
            end else begin
                q = sa % sb; res = q[15:0];
            end
            z = (res == 16'd0); n = res[15];
        end
        if (ENGINE) return {hi, res, z, n, 1'b0, v};
        else return {16'd0, 16'd0, 4'b0001};
    endfunction

    task automatic step_sc(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [19:0] e;
        e = model_sc(o, a, b);
        op = o; A = a; B = b;
        @(posedge clk); #1;
        check($sformatf("op%0d_result", o), {16'd0, result}, {16'd0, e[19:4]});
        check($sformatf("op%0d_high", o), {16'd0, result_high}, 32'd0);
        check($sformatf("op%0d_flags", o), {28'd0, Z, N, C, V}, {28'd0, e[3:0]});
        check($sformatf("op%0d_done", o), {29'd0, done_div, done_mod, done_mul}, 32'd0);
    endtask

    // Launch an engine op; with disturb, a second start and an op change are
    // driven while it runs and must have no effect on the outcome.
    task automatic run_eng(input logic [4:0] o, input logic [15:0] a, input logic [15:0] b, input bit disturb);
        logic [35:0] e;
        logic [2:0]  dexp;
        int lat;
        e    = model_eng(o, a, b);
        dexp = {o == 5'd2, o == 5'd5, o == 5'd7};
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int i = 0; i <= 40; i++) begin
            if (done_div || done_mod || done_mul) begin
                lat = i;
                break;
            end
            if (disturb && i == 0) begin op = 5'd7; A = ~a; B = 16'h1234; start = 1'b1; end
            if (disturb && i == 1) begin op = 5'd0; start = 1'b0; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        check($sformatf("op%0d_latency", o), lat, ENGINE ? 32'd17 : 32'd0);
        check($sformatf("op%0d_eresult", o), {16'd0, result}, {16'd0, e[19:4]});
        check($sformatf("op%0d_ehigh", o), {16'd0, result_high}, {16'd0, e[35:20]});
        check($sformatf("op%0d_eflags", o), {28'd0, Z, N, C, V}, {28'd0, e[3:0]});
        check($sformatf("op%0d_edone", o), {29'd0, done_div, done_mod, done_mul}, {29'd0, dexp});
        if (!disturb) begin
            @(posedge clk); #1;
            check($sformatf("op%0d_pulse", o), {29'd0, done_div, done_mod, done_mul}, 32'd0);
            check($sformatf("op%0d_hold", o), {12'd0, result, Z, N, C, V}, {12'd0, e[19:0]});
        end
    endtask

    initial begin
        logic [4:0] ro;
        bit seen;
        rst = 1'b1; start = 1'b0; op = 5'd0; A = 16'd0; B = 16'd0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_result", {result, result_high}, 32'd0);
        check("reset_flags", {25'd0, Z, N, C, V, done_div, done_mod, done_mul}, 32'd0);
        rst = 1'b0;

        // Test-plan single-cycle cases and boundaries.
        step_sc(5'd0,  16'h00F0, 16'h0FF0);
        step_sc(5'd1,  16'd10,   16'd0);
        step_sc(5'd1,  16'd0,    16'd0);
        step_sc(5'd4,  16'h0001, 16'd2);
        step_sc(5'd4,  16'h8000, 16'd0);
        step_sc(5'd4,  16'h8000, 16'd1);
        step_sc(5'd11, 16'h00F0, 16'd4);
        step_sc(5'd11, 16'h0001, 16'd1);
        step_sc(5'd12, 16'h00F0, 16'd5);
        step_sc(5'd13, 16'h00F0, 16'd5);
        step_sc(5'd14, 16'd15,   16'd16);
        step_sc(5'd15, 16'd16,   16'd16);
        step_sc(5'd17, 16'd5,    16'd10);
        step_sc(5'd10, 16'h7FFF, 16'd1);
        step_sc(5'd3,  16'hFFFF, 16'd0);
        step_sc(5'd20, 16'h1234, 16'h5678);

        // Test-plan engine cases and boundaries.
        run_eng(5'd2, 16'hFFEC, 16'd5, 1'b0);
        run_eng(5'd5, 16'hFFF8, 16'd3, 1'b0);
        run_eng(5'd2, 16'd100,  16'd0, 1'b0);
        run_eng(5'd5, 16'hABCD, 16'd0, 1'b0);
        run_eng(5'd2, 16'h8000, 16'hFFFF, 1'b0);
        run_eng(5'd7, 16'hFFF5, 16'd5, 1'b0);
        run_eng(5'd7, 16'd300,  16'd300, 1'b0);
        run_eng(5'd7, 16'h8000, 16'h8000, 1'b0);
        run_eng(5'd2, 16'd1000, 16'hFFF9, 1'b1);
        step_sc(5'd9, 16'h0F0F, 16'h00FF);

        // Reset in the middle of a MUL: everything clears, no done follows.
        op = 5'd7; A = 16'hFFF5; B = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out", {result, result_high}, 32'd0);
        check("midrst_flags", {25'd0, Z, N, C, V, done_div, done_mod, done_mul}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (done_div || done_mod || done_mul) seen = 1'b1;
        end
        check("midrst_nodone", {31'd0, seen}, 32'd0);
        check("midrst_hold", {16'd0, result}, 32'd0);

        // start with a single-cycle opcode launches nothing.
        op = 5'd0; A = 16'h00FF; B = 16'h0F0F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_div || done_mod || done_mul) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("start_op0_nodone", {31'd0, seen}, 32'd0);
        check("start_op0_result", {16'd0, result}, 32'h000F);

        // Randomized single-cycle operations.
        for (int i = 0; i < 60; i++) begin
            ro = 5'($urandom_range(0, 31));
            if (ro == 5'd2 || ro == 5'd5 || ro == 5'd7) ro = 5'd14;
            step_sc(ro, 16'($urandom), 16'($urandom));
        end

        // Randomized engine operations.
        for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 2))
                0: ro = 5'd2;
                1: ro = 5'd5;
                default: ro = 5'd7;
            endcase
            run_eng(ro, 16'($urandom), (i == 3) ? 16'd0 : 16'($urandom_range(0, 65535) >> $urandom_range(0, 14)), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
